// File: rtl/decode_stage.sv
// RV32I decode stage: buffers fetch bundles, serialises valid lanes in program order, emits one decoded instruction per cycle.
// Latency: a bundle accepted into an empty stage presents its first lane one edge later; one instruction per cycle after that.
// Backpressure: output holds while dinst_valid_out && !dinst_ready_in; bundle_ready_out drops when the bundle FIFO is full.
// Optional feature: define DECODE_RV32M_EN to decode the RV32M multiply/divide group as OP instructions.

package decode_stage_pkg;

  typedef enum logic [3:0] {
    IT_UNSUPPORTED = 4'd0,
    IT_OP          = 4'd1,
    IT_OPIMM       = 4'd2,
    IT_LOAD        = 4'd3,
    IT_STORE       = 4'd4,
    IT_BRANCH      = 4'd5,
    IT_JAL         = 4'd6,
    IT_JALR        = 4'd7,
    IT_LUI         = 4'd8,
    IT_AUIPC       = 4'd9
  } itype_t;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alufunc_t;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6
  } brfunc_t;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } memfunc_t;

  // All-zero value doubles as the reset value and the illegal-instruction value.
  typedef struct packed {
    itype_t      itype;
    alufunc_t    alufunc;
    brfunc_t     brfunc;
    memfunc_t    memfunc;
    logic [4:0]  dst;
    logic        dst_valid;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [31:0] imm;
  } decoded_inst_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

endpackage

// Generic bundle FIFO with synchronous flush and an occupancy count.
// Latency: a pushed entry is visible at the head the edge after the push.
// Backpressure: caller must not push when full nor pop when empty.
module decode_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage array: payload only, no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; flush empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       flush_in,
  input  logic                       bundle_valid_in,
  output logic                       bundle_ready_out,
  input  logic [32*LANES-1:0]        bundle_inst_in,
  input  logic [31:0]                bundle_pc_in,
  input  logic [LANES-1:0]           bundle_mask_in,
  output logic                       dinst_valid_out,
  input  logic                       dinst_ready_in,
  output decoded_inst_t              dinst_out,
  output logic [31:0]                pc_out,
  output logic                       illegal_out,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef struct packed {
    logic [LANES-1:0]    mask;
    logic [31:0]         pc;
    logic [32*LANES-1:0] inst;
  } bundle_t;

  bundle_t       wr_bundle;
  bundle_t       head;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          empty;

  logic [LW-1:0] lane_ptr;
  logic [LW-1:0] sel_lane;
  logic          sel_found;
  logic          sel_last;
  logic [31:0]   sel_inst;
  logic [31:0]   sel_pc;
  logic          load;
  decoded_inst_t dec;

  decoded_inst_t dinst_q;
  logic [31:0]   pc_q;
  logic          illegal_q;
  logic          valid_q;

  // Full RV32I field extraction and legality check; illegal encodings collapse to all-zero.
  function automatic decoded_inst_t decode_inst(input logic [31:0] inst);
    decoded_inst_t d;
    logic          legal;
    logic          writes_rd;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [31:0]   imm_i;
    logic [31:0]   imm_s;
    logic [31:0]   imm_b;
    logic [31:0]   imm_u;
    logic [31:0]   imm_j;
    rd        = inst[11:7];
    rs1       = inst[19:15];
    rs2       = inst[24:20];
    f3        = inst[14:12];
    f7        = inst[31:25];
    imm_i     = {{20{inst[31]}}, inst[31:20]};
    imm_s     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u     = {inst[31:12], 12'b0};
    imm_j     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    d         = '0;
    legal     = 1'b1;
    writes_rd = 1'b0;
    case (inst[6:0])
      OPC_OP: begin
        d.itype   = IT_OP;
        writes_rd = 1'b1;
        d.src1    = rs1;
        d.src2    = rs2;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'd0: d.alufunc = ALU_ADD;
              3'd1: d.alufunc = ALU_SLL;
              3'd2: d.alufunc = ALU_SLT;
              3'd3: d.alufunc = ALU_SLTU;
              3'd4: d.alufunc = ALU_XOR;
              3'd5: d.alufunc = ALU_SRL;
              3'd6: d.alufunc = ALU_OR;
              3'd7: d.alufunc = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'd0)      d.alufunc = ALU_SUB;
            else if (f3 == 3'd5) d.alufunc = ALU_SRA;
            else                 legal = 1'b0;
          end
`ifdef DECODE_RV32M_EN
          7'b0000001: begin
            case (f3)
              3'd0: d.alufunc = ALU_MUL;
              3'd1: d.alufunc = ALU_MULH;
              3'd2: d.alufunc = ALU_MULHSU;
              3'd3: d.alufunc = ALU_MULHU;
              3'd4: d.alufunc = ALU_DIV;
              3'd5: d.alufunc = ALU_DIVU;
              3'd6: d.alufunc = ALU_REM;
              3'd7: d.alufunc = ALU_REMU;
            endcase
          end
`endif
          default: legal = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        d.itype   = IT_OPIMM;
        writes_rd = 1'b1;
        d.src1    = rs1;
        d.imm     = imm_i;
        case (f3)
          3'd0: d.alufunc = ALU_ADD;
          3'd1: begin
            d.alufunc = ALU_SLL;
            if (f7 != 7'b0000000) legal = 1'b0;
          end
          3'd2: d.alufunc = ALU_SLT;
          3'd3: d.alufunc = ALU_SLTU;
          3'd4: d.alufunc = ALU_XOR;
          3'd5: begin
            if (f7 == 7'b0000000)      d.alufunc = ALU_SRL;
            else if (f7 == 7'b0100000) d.alufunc = ALU_SRA;
            else                       legal = 1'b0;
          end
          3'd6: d.alufunc = ALU_OR;
          3'd7: d.alufunc = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        d.itype   = IT_LOAD;
        writes_rd = 1'b1;
        d.src1    = rs1;
        d.imm     = imm_i;
        case (f3)
          3'd0:    d.memfunc = MEM_LB;
          3'd1:    d.memfunc = MEM_LH;
          3'd2:    d.memfunc = MEM_LW;
          3'd4:    d.memfunc = MEM_LBU;
          3'd5:    d.memfunc = MEM_LHU;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        d.itype = IT_STORE;
        d.src1  = rs1;
        d.src2  = rs2;
        d.imm   = imm_s;
        case (f3)
          3'd0:    d.memfunc = MEM_SB;
          3'd1:    d.memfunc = MEM_SH;
          3'd2:    d.memfunc = MEM_SW;
          default: legal = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        d.itype = IT_BRANCH;
        d.src1  = rs1;
        d.src2  = rs2;
        d.imm   = imm_b;
        case (f3)
          3'd0:    d.brfunc = BR_EQ;
          3'd1:    d.brfunc = BR_NE;
          3'd4:    d.brfunc = BR_LT;
          3'd5:    d.brfunc = BR_GE;
          3'd6:    d.brfunc = BR_LTU;
          3'd7:    d.brfunc = BR_GEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_JALR: begin
        d.itype   = IT_JALR;
        writes_rd = 1'b1;
        d.src1    = rs1;
        d.imm     = imm_i;
        if (f3 != 3'd0) legal = 1'b0;
      end
      OPC_JAL: begin
        d.itype   = IT_JAL;
        writes_rd = 1'b1;
        d.imm     = imm_j;
      end
      OPC_LUI: begin
        d.itype   = IT_LUI;
        writes_rd = 1'b1;
        d.imm     = imm_u;
      end
      OPC_AUIPC: begin
        d.itype   = IT_AUIPC;
        writes_rd = 1'b1;
        d.imm     = imm_u;
      end
      default: legal = 1'b0;
    endcase
    if (writes_rd) begin
      d.dst       = rd;
      d.dst_valid = (rd != 5'd0);
    end
    if (!legal) d = '0;
    return d;
  endfunction

  assign bundle_ready_out = rst_n_in && (count < CW'(DEPTH));
  assign push             = bundle_valid_in && bundle_ready_out && !flush_in && (|bundle_mask_in);
  assign empty            = (count == '0);

  // Pack the incoming bundle; all-zero-mask bundles are accepted but never written.
  always_comb begin
    wr_bundle      = '0;
    wr_bundle.mask = bundle_mask_in;
    wr_bundle.pc   = bundle_pc_in;
    wr_bundle.inst = bundle_inst_in;
  end

  decode_fifo #(
    .WIDTH ($bits(bundle_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .flush    (flush_in),
    .push     (push),
    .push_dat (wr_bundle),
    .pop      (pop),
    .head_dat (head),
    .count    (count)
  );

  // Pick the lowest set lane at or above the lane pointer; note whether any set lane lies beyond it.
  always_comb begin
    sel_found = 1'b0;
    sel_lane  = '0;
    sel_last  = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (head.mask[i] && (i >= int'(lane_ptr))) begin
        if (!sel_found) begin
          sel_found = 1'b1;
          sel_lane  = LW'(i);
        end else begin
          sel_last = 1'b0;
        end
      end
    end
    sel_found = sel_found && !empty;
  end

  // Route the selected lane's instruction word and compute its PC (wraps mod 2^32).
  always_comb begin
    sel_inst = '0;
    for (int i = 0; i < LANES; i++) begin
      if (LW'(i) == sel_lane) sel_inst = head.inst[32*i +: 32];
    end
    sel_pc = head.pc + {{(30-LW){1'b0}}, sel_lane, 2'b00};
    dec    = decode_inst(sel_inst);
  end

  assign load = sel_found && (!valid_q || dinst_ready_in);
  assign pop  = load && sel_last;

  // Lane pointer advances past each emitted lane and returns to 0 when the bundle retires.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lane_ptr <= '0;
    end else if (flush_in) begin
      lane_ptr <= '0;
    end else if (load) begin
      lane_ptr <= sel_last ? '0 : sel_lane + LW'(1);
    end
  end

  // Output register: loads a decoded lane when empty or being drained, holds while stalled.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q   <= 1'b0;
      dinst_q   <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
    end else if (flush_in) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q   <= 1'b1;
      dinst_q   <= dec;
      pc_q      <= sel_pc;
      illegal_q <= (dec.itype == IT_UNSUPPORTED);
    end else if (dinst_ready_in) begin
      valid_q <= 1'b0;
    end
  end

  assign dinst_valid_out = valid_q;
  assign dinst_out       = dinst_q;
  assign pc_out          = pc_q;
  assign illegal_out     = illegal_q;
  assign occupancy_out   = count;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage (LANES=2, DEPTH=4): directed bundles, expected decodes queued at issue time.
// A negedge monitor pops and compares on every output handshake and checks output stability while stalled.
// The MUL expectation follows DECODE_RV32M_EN so the bench matches either build.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int LANES = 2;
  localparam int DEPTH = 4;

  typedef struct packed {
    decoded_inst_t d;
    logic [31:0]   pc;
    logic          ill;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          bundle_valid = 1'b0;
  logic          bundle_ready;
  logic [63:0]   bundle_inst = '0;
  logic [31:0]   bundle_pc = '0;
  logic [1:0]    bundle_mask = '0;
  logic          dinst_valid;
  logic          dinst_ready = 1'b0;
  decoded_inst_t dinst;
  logic [31:0]   pc;
  logic          illegal;
  logic [2:0]    occupancy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   push_cyc = 0;
  exp_t sb[$];
  int   hs_cyc[$];
  logic stall_prev = 1'b0;
  logic [96:0] stall_snap = '0;

  decode_stage #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .flush_in         (flush),
    .bundle_valid_in  (bundle_valid),
    .bundle_ready_out (bundle_ready),
    .bundle_inst_in   (bundle_inst),
    .bundle_pc_in     (bundle_pc),
    .bundle_mask_in   (bundle_mask),
    .dinst_valid_out  (dinst_valid),
    .dinst_ready_in   (dinst_ready),
    .dinst_out        (dinst),
    .pc_out           (pc),
    .illegal_out      (illegal),
    .occupancy_out    (occupancy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic decoded_inst_t mk(input itype_t it, input alufunc_t a, input brfunc_t b,
                                       input memfunc_t m, input logic [4:0] dst, input logic dv,
                                       input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] imm);
    decoded_inst_t d;
    d.itype = it; d.alufunc = a; d.brfunc = b; d.memfunc = m;
    d.dst = dst; d.dst_valid = dv; d.src1 = s1; d.src2 = s2; d.imm = imm;
    return d;
  endfunction

  task automatic expect_out(input decoded_inst_t d, input logic [31:0] p, input logic ill);
    exp_t e;
    e.d = d; e.pc = p; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] p, input logic [1:0] m);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    bundle_valid = 1'b1;
    bundle_inst  = {i1, i0};
    bundle_pc    = p;
    bundle_mask  = m;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bundle_ready;
      @(posedge clk);
      n++;
    end
    #1;
    bundle_valid = 1'b0;
    push_cyc = cyc;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL push_timeout pc=%h accepted=0 required=1", p);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain remaining=%0d required=0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: stall stability and scoreboard comparison on every handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!dinst_valid || {dinst, pc, illegal} !== stall_snap) begin
          errors++;
          $display("FAIL stall_hold actual=%h required=%h", {dinst_valid, dinst, pc, illegal}, {1'b1, stall_snap});
        end
      end
      if (dinst_valid && dinst_ready) begin
        exp_t e;
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output pc=%h dinst=%h required=none", pc, dinst);
        end else begin
          e = sb.pop_front();
          checks += 3;
          if (dinst !== e.d) begin
            errors++;
            $display("FAIL dinst pc=%h actual=%h required=%h", e.pc, dinst, e.d);
          end
          if (pc !== e.pc) begin
            errors++;
            $display("FAIL pc actual=%h required=%h", pc, e.pc);
          end
          if (illegal !== e.ill) begin
            errors++;
            $display("FAIL illegal pc=%h actual=%b required=%b", e.pc, illegal, e.ill);
          end
        end
      end
      stall_prev = dinst_valid && !dinst_ready && !flush;
      stall_snap = {dinst, pc, illegal};
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_valid", dinst_valid, 0);
    chk("rst_ready", bundle_ready, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_dinst", dinst, 0);
    chk("rst_pc", pc, 0);
    chk("rst_illegal", illegal, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dinst_ready = 1'b1;
    @(posedge clk);
    #1;

    // addi x1,x0,5 then sub x2,x1,x2: back-to-back outputs, first one edge after acceptance
    hs_cyc.delete();
    expect_out(mk(IT_OPIMM, ALU_ADD, BR_NONE, MEM_NONE, 5'd1, 1'b1, 5'd0, 5'd0, 32'd5), 32'h100, 1'b0);
    expect_out(mk(IT_OP, ALU_SUB, BR_NONE, MEM_NONE, 5'd2, 1'b1, 5'd1, 5'd2, 32'd0), 32'h104, 1'b0);
    push(32'h00500093, 32'h40208133, 32'h100, 2'b11);
    drain("t1");
    chk("t1_hs_count", hs_cyc.size(), 2);
    if (hs_cyc.size() >= 2) begin
      chk("t1_first_latency", hs_cyc[0], push_cyc + 1);
      chk("t1_second_cycle", hs_cyc[1], push_cyc + 2);
    end

    // Mask 2'b10: only lane 1 (sw x8,8(x2)) at PC+4
    expect_out(mk(IT_STORE, ALU_ADD, BR_NONE, MEM_SW, 5'd0, 1'b0, 5'd2, 5'd8, 32'd8), 32'h204, 1'b0);
    push(32'h00500093, 32'h00812423, 32'h200, 2'b10);
    drain("t2");

    // Mask 2'b00: accepted, dropped, no output, occupancy stays 0
    push(32'h00500093, 32'h00812423, 32'h280, 2'b00);
    chk("t3_occ_after_empty_mask", occupancy, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_no_output", dinst_valid, 0);

    // Illegal opcode at the top of the address space; MUL lane wraps its PC to 0
    expect_out('0, 32'hFFFF_FFFC, 1'b1);
`ifdef DECODE_RV32M_EN
    expect_out(mk(IT_OP, ALU_MUL, BR_NONE, MEM_NONE, 5'd3, 1'b1, 5'd1, 5'd2, 32'd0), 32'h0, 1'b0);
`else
    expect_out('0, 32'h0, 1'b1);
`endif
    push(32'h0000707F, 32'h022081B3, 32'hFFFF_FFFC, 2'b11);
    drain("t4");

    // Fill the FIFO with the consumer stalled, then release; pointers wrap
    dinst_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      expect_out(mk(IT_OPIMM, ALU_ADD, BR_NONE, MEM_NONE, 5'(k + 1), 1'b1, 5'd0, 5'd0, 32'(10 + k)),
                 32'h1000 + 32'(16 * k), 1'b0);
      expect_out(mk(IT_LUI, ALU_ADD, BR_NONE, MEM_NONE, 5'(k + 5), 1'b1, 5'd0, 5'd0, 32'(k + 1) << 12),
                 32'h1004 + 32'(16 * k), 1'b0);
      push((32'(10 + k) << 20) | (32'(k + 1) << 7) | 32'h13,
           (32'(k + 1) << 12) | (32'(k + 5) << 7) | 32'h37,
           32'h1000 + 32'(16 * k), 2'b11);
    end
    chk("t5_full_occ", occupancy, DEPTH);
    chk("t5_full_ready", bundle_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_stalled_valid", dinst_valid, 1);
    dinst_ready = 1'b1;
    drain("t5");

    // Flush with a same-cycle push while 3 bundles are queued
    dinst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push(32'h00500093, 32'h40208133, 32'h2000 + 32'(8 * k), 2'b11);
    end
    chk("t6_pre_flush_occ", occupancy, 3);
    flush = 1'b1;
    bundle_valid = 1'b1;
    bundle_inst = {32'h00812423, 32'h00500093};
    bundle_pc = 32'h3000;
    bundle_mask = 2'b11;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bundle_valid = 1'b0;
    chk("t6_flush_valid", dinst_valid, 0);
    chk("t6_flush_occ", occupancy, 0);
    dinst_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_nothing_after_flush", dinst_valid, 0);

    // Recovery after flush: jal x1,8 then bne x1,x2,16
    expect_out(mk(IT_JAL, ALU_ADD, BR_NONE, MEM_NONE, 5'd1, 1'b1, 5'd0, 5'd0, 32'd8), 32'h400, 1'b0);
    expect_out(mk(IT_BRANCH, ALU_ADD, BR_NE, MEM_NONE, 5'd0, 1'b0, 5'd1, 5'd2, 32'd16), 32'h404, 1'b0);
    push(32'h008000EF, 32'h00209863, 32'h400, 2'b11);
    drain("t7");

    // Asynchronous reset mid-stream clears outputs without a clock edge
    dinst_ready = 1'b0;
    push(32'h00500093, 32'h40208133, 32'h500, 2'b11);
    repeat (2) @(posedge clk);
    #3;
    chk("t8_pre_valid", dinst_valid, 1);
    chk("t8_pre_occ", occupancy, 1);
    rst_n = 1'b0;
    #1;
    chk("t8_rst_valid", dinst_valid, 0);
    chk("t8_rst_occ", occupancy, 0);
    chk("t8_rst_ready", bundle_ready, 0);
    chk("t8_rst_pc", pc, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
